bios_burst_sink: RTL and testbench

//  System-side consumer of the BIOS download word stream. The top level packs data_io bytes into
//  16-bit words in a 64-word ping-pong buffer. It raises BIOS_WR when a 32-word half is ready.

---
 rtl/next186_bios_pkg.sv | 14 +
 rtl/bios_burst_sink_fifo.sv | 47 ++++
 rtl/bios_burst_sink.sv | 138 +++++++++++++
 tb/tb_bios_burst_sink.sv | 377 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/next186_bios_pkg.sv
// Shared types and widths for the BIOS download sink.
package next186_bios_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PULL  = 2'd1,
        GUARD = 2'd2
    } state_t;

    localparam int unsigned BIOS_WORD_W  = 16;
    localparam int unsigned BIOS_IDX_W   = 13;
    localparam int unsigned GUARD_CYCLES = 2;

endpackage

// File: rtl/bios_burst_sink_fifo.sv
// First-word-fall-through word FIFO; reset clears the pointers only, storage is left as-is.
module bios_word_fifo #(
    parameter int unsigned DEPTH = 64,
    parameter int unsigned W     = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [W-1:0]             din,
    output logic [W-1:0]             dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   free_cnt
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;
    logic [AW:0]  used;
    logic         push_ok;
    logic         pop_ok;

    assign used     = wr_ptr - rd_ptr;
    assign full     = (used == (AW+1)'(DEPTH));
    assign empty    = (used == '0);
    assign free_cnt = (AW+1)'(DEPTH) - used;
    assign push_ok  = push && !full;
    assign pop_ok   = pop && !empty;
    assign dout     = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/bios_burst_sink.sv
// Pulls BIOS words from the ping-pong producer in bursts and streams them to the SDRAM write port.
// Optional running checksum of committed words: define BIOS_SINK_CHECKSUM_EN.
module bios_burst_sink
    import next186_bios_pkg::*;
#(
    parameter int unsigned BURST_WORDS = 32,
    parameter int unsigned FIFO_DEPTH  = 64,
    parameter int unsigned MEM_AW      = 18,
    parameter int unsigned BASE_ADDR   = 'h3F000
) (
    input  logic                   clk_sdr,
    input  logic                   reset_n,
    input  logic                   dl_start_i,
    input  logic                   bios_wr_i,
    input  logic [BIOS_WORD_W-1:0] bios_din_i,
    output logic                   bios_req_o,
    output logic                   mem_we_o,
    output logic [MEM_AW-1:0]      mem_addr_o,
    output logic [BIOS_WORD_W-1:0] mem_dout_o,
    input  logic                   mem_ack_i,
    output logic                   busy_o,
    output logic [BIOS_IDX_W-1:0]  word_cnt_o,
    output logic [BIOS_WORD_W-1:0] checksum_o
);
    localparam int unsigned CNT_W = $clog2(BURST_WORDS);
    localparam int unsigned G_W   = $clog2(GUARD_CYCLES + 1);
    localparam int unsigned FAW   = $clog2(FIFO_DEPTH);

    state_t                 state;
    logic [CNT_W-1:0]       pull_cnt;
    logic [G_W-1:0]         guard_cnt;
    logic                   req_d;
    logic [BIOS_IDX_W-1:0]  idx;

    logic                   fifo_pop;
    logic [BIOS_WORD_W-1:0] fifo_dout;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic [FAW:0]           fifo_free;

    assign fifo_pop   = !fifo_empty && !mem_we_o;
    assign word_cnt_o = idx;

    bios_word_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (BIOS_WORD_W)
    ) u_fifo (
        .clk      (clk_sdr),
        .rst_n    (reset_n),
        .push     (req_d),
        .pop      (fifo_pop),
        .din      (bios_din_i),
        .dout     (fifo_dout),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .free_cnt (fifo_free)
    );

    // Pull side: a burst only starts when the whole half is guaranteed to fit.
    always_ff @(posedge clk_sdr or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            pull_cnt   <= '0;
            guard_cnt  <= '0;
            bios_req_o <= 1'b0;
            req_d      <= 1'b0;
            busy_o     <= 1'b0;
        end else begin
            req_d  <= bios_req_o;
            busy_o <= (state != IDLE) || !fifo_empty;
            case (state)
                IDLE: begin
                    if (bios_wr_i && (fifo_free >= (FAW+1)'(BURST_WORDS))) begin
                        state      <= PULL;
                        bios_req_o <= 1'b1;
                        pull_cnt   <= '0;
                    end
                end
                PULL: begin
                    if (pull_cnt == CNT_W'(BURST_WORDS - 1)) begin
                        state      <= GUARD;
                        bios_req_o <= 1'b0;
                        guard_cnt  <= '0;
                    end else begin
                        pull_cnt <= pull_cnt + 1'b1;
                    end
                end
                GUARD: begin
                    if (guard_cnt == G_W'(GUARD_CYCLES - 1)) state <= IDLE;
                    else                                      guard_cnt <= guard_cnt + 1'b1;
                end
                default: begin
                    state      <= IDLE;
                    bios_req_o <= 1'b0;
                end
            endcase
        end
    end

    // Drain side: one outstanding SDRAM write, held until acknowledged.
    always_ff @(posedge clk_sdr or negedge reset_n) begin
        if (!reset_n) begin
            mem_we_o   <= 1'b0;
            mem_addr_o <= '0;
            mem_dout_o <= '0;
            idx        <= '0;
        end else begin
            if (fifo_pop) begin
                mem_we_o   <= 1'b1;
                mem_dout_o <= fifo_dout;
                mem_addr_o <= MEM_AW'(BASE_ADDR) + MEM_AW'(idx);
            end else if (mem_we_o && mem_ack_i) begin
                mem_we_o <= 1'b0;
                idx      <= idx + 1'b1;
            end
            if (dl_start_i) idx <= '0;
        end
    end

`ifdef BIOS_SINK_CHECKSUM_EN
    logic [BIOS_WORD_W-1:0] sum;

    always_ff @(posedge clk_sdr or negedge reset_n) begin
        if (!reset_n)                  sum <= '0;
        else if (dl_start_i)           sum <= '0;
        else if (mem_we_o && mem_ack_i) sum <= sum + mem_dout_o;
    end

    assign checksum_o = sum;
`else
    assign checksum_o = '0;
`endif

    // The entry check on free space makes a push into a full FIFO impossible.
    assert property (@(posedge clk_sdr) disable iff (!reset_n) !(req_d && fifo_full))
        else $error("bios_burst_sink: word pushed into full FIFO and dropped");

endmodule

// File: tb/tb_bios_burst_sink.sv
// Scoreboard bench: producer and SDRAM models run in the background, scenario tasks compare.
module tb_bios_burst_sink;

    localparam int unsigned BASE = 'h3F000;

    typedef struct packed {
        logic [17:0] addr;
        logic [15:0] data;
    } wr_t;

    logic        clk_sdr = 1'b0;
    logic        reset_n = 1'b0;
    logic        dl_start = 1'b0;
    logic        bios_wr = 1'b0;
    logic [15:0] bios_din = '0;
    logic        bios_req;
    logic        mem_we;
    logic [17:0] mem_addr;
    logic [15:0] mem_dout;
    logic        mem_ack = 1'b0;
    logic        busy;
    logic [12:0] word_cnt;
    logic [15:0] checksum;

    int          n_cmp = 0;
    int          n_bad = 0;
    wr_t         exp_q[$];
    wr_t         obs_q[$];
    logic [15:0] dq[$];
    int          pending = 0;
    int          halves_done = 0;
    int          cycle = 0;
    int          run = 0;
    int          last_run = 0;
    int          fall_cycle = 0;
    int          last_gap = 0;
    logic        prev_req = 1'b0;
    logic        seen = 1'b0;
    bit          ack_en = 1'b1;
    logic [15:0] next_word = '0;
    logic [12:0] model_idx = '0;
    logic [15:0] model_sum = '0;

    bios_burst_sink dut (
        .clk_sdr    (clk_sdr),
        .reset_n    (reset_n),
        .dl_start_i (dl_start),
        .bios_wr_i  (bios_wr),
        .bios_din_i (bios_din),
        .bios_req_o (bios_req),
        .mem_we_o   (mem_we),
        .mem_addr_o (mem_addr),
        .mem_dout_o (mem_dout),
        .mem_ack_i  (mem_ack),
        .busy_o     (busy),
        .word_cnt_o (word_cnt),
        .checksum_o (checksum)
    );

    always #5 clk_sdr = ~clk_sdr;

    function automatic logic [15:0] exp_chk();
`ifdef BIOS_SINK_CHECKSUM_EN
        return model_sum;
`else
        return 16'h0000;
`endif
    endfunction

    // Producer and SDRAM responder, evaluated just after each rising edge.
    initial begin
        logic [15:0] w;
        forever begin
            @(posedge clk_sdr);
            #1;
            cycle++;
            if (prev_req) begin
                if (dq.size() > 0) w = dq.pop_front();
                else begin w = next_word; next_word = next_word + 16'd1; end
                bios_din = w;
                exp_q.push_back('{addr: 18'(BASE + 32'(model_idx)), data: w});
                model_idx = model_idx + 13'd1;
                model_sum = model_sum + w;
            end
            if (bios_req && !prev_req) begin
                last_gap = cycle - fall_cycle;
                run = 0;
            end
            if (bios_req) run++;
            if (!bios_req && prev_req) begin
                last_run = run;
                fall_cycle = cycle;
                halves_done++;
                if (pending > 0) pending--;
            end
            bios_wr  = (pending > 0);
            prev_req = bios_req;
            if (mem_we && !seen) begin
                obs_q.push_back({mem_addr, mem_dout});
                seen = 1'b1;
            end
            if (!mem_we) seen = 1'b0;
            mem_ack = mem_we && ack_en && !mem_ack;
        end
    end

    task automatic wait_obs(input int n, input int budget);
        for (int i = 0; i < budget && obs_q.size() < n; i++) @(negedge clk_sdr);
    endtask

    task automatic pulse_dl_start();
        @(negedge clk_sdr);
        dl_start = 1'b1;
        @(negedge clk_sdr);
        dl_start = 1'b0;
        model_idx = '0;
        model_sum = '0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(negedge clk_sdr);
        reset_n = 1'b1;
        @(negedge clk_sdr);
        n_cmp++;
        if ({bios_req, mem_we, busy} !== 3'b000) begin
            n_bad++;
            $display("FAIL reset_ctl: got req/we/busy=%b want 000", {bios_req, mem_we, busy});
        end
        n_cmp++;
        if ({mem_addr, mem_dout, word_cnt, checksum} !== '0) begin
            n_bad++;
            $display("FAIL reset_data: got addr=%h dout=%h cnt=%0d chk=%h want all 0",
                     mem_addr, mem_dout, word_cnt, checksum);
        end
    endtask

    task automatic test_single_burst();
        wr_t o, e;
        next_word = 16'h0000;
        pending = 1;
        wait_obs(32, 1000);
        repeat (4) @(negedge clk_sdr);
        n_cmp++;
        if (obs_q.size() != 32 || exp_q.size() != 32) begin
            n_bad++;
            $display("FAIL single_count: got obs=%0d exp=%0d want 32", obs_q.size(), exp_q.size());
        end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            n_cmp++;
            if (o !== e) begin
                n_bad++;
                $display("FAIL single_write: got %h/%h want %h/%h", o.addr, o.data, e.addr, e.data);
            end
        end
        n_cmp++;
        if (last_run != 32) begin
            n_bad++;
            $display("FAIL single_req_len: got %0d want 32", last_run);
        end
        n_cmp++;
        if (word_cnt !== 13'd32 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL single_cnt: got cnt=%0d busy=%b want 32/0", word_cnt, busy);
        end
        n_cmp++;
        if (checksum !== exp_chk()) begin
            n_bad++;
            $display("FAIL single_chk: got %h want %h", checksum, exp_chk());
        end
    endtask

    task automatic test_back_to_back();
        wr_t o, e;
        pulse_dl_start();
        next_word = 16'h0000;
        pending = 2;
        wait_obs(64, 2000);
        repeat (4) @(negedge clk_sdr);
        n_cmp++;
        if (obs_q.size() != 64 || exp_q.size() != 64) begin
            n_bad++;
            $display("FAIL b2b_count: got obs=%0d exp=%0d want 64", obs_q.size(), exp_q.size());
        end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            n_cmp++;
            if (o !== e) begin
                n_bad++;
                $display("FAIL b2b_write: got %h/%h want %h/%h", o.addr, o.data, e.addr, e.data);
            end
        end
        n_cmp++;
        if (last_gap < 2 || last_gap > 3) begin
            n_bad++;
            $display("FAIL b2b_gap: got %0d req-low cycles want 2..3", last_gap);
        end
        n_cmp++;
        if (word_cnt !== 13'd64) begin
            n_bad++;
            $display("FAIL b2b_cnt: got %0d want 64", word_cnt);
        end
    endtask

    task automatic test_stall();
        wr_t o, e;
        int h0;
        pulse_dl_start();
        next_word = 16'h1000;
        ack_en = 1'b0;
        h0 = halves_done;
        pending = 3;
        repeat (200) @(negedge clk_sdr);
        n_cmp++;
        if (halves_done - h0 != 2 || obs_q.size() != 1 || busy !== 1'b1) begin
            n_bad++;
            $display("FAIL stall_hold: got pulls=%0d writes=%0d busy=%b want 2/1/1",
                     halves_done - h0, obs_q.size(), busy);
        end
        ack_en = 1'b1;
        wait_obs(96, 3000);
        repeat (4) @(negedge clk_sdr);
        n_cmp++;
        if (halves_done - h0 != 3 || obs_q.size() != 96 || exp_q.size() != 96) begin
            n_bad++;
            $display("FAIL stall_count: got pulls=%0d obs=%0d exp=%0d want 3/96/96",
                     halves_done - h0, obs_q.size(), exp_q.size());
        end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            n_cmp++;
            if (o !== e) begin
                n_bad++;
                $display("FAIL stall_write: got %h/%h want %h/%h", o.addr, o.data, e.addr, e.data);
            end
        end
        n_cmp++;
        if (word_cnt !== 13'd96 || checksum !== exp_chk()) begin
            n_bad++;
            $display("FAIL stall_cnt: got cnt=%0d chk=%h want 96/%h", word_cnt, checksum, exp_chk());
        end
    endtask

    task automatic test_reset_mid_pull();
        wr_t o, e;
        next_word = 16'h2000;
        pending = 1;
        for (int i = 0; i < 200 && !(bios_req && run == 10); i++) @(negedge clk_sdr);
        n_cmp++;
        if (!(bios_req && run == 10)) begin
            n_bad++;
            $display("FAIL midrst_start: got req=%b run=%0d want 1/10", bios_req, run);
        end
        reset_n = 1'b0;
        @(negedge clk_sdr);
        n_cmp++;
        if ({bios_req, mem_we, busy, mem_addr, mem_dout, word_cnt, checksum} !== '0) begin
            n_bad++;
            $display("FAIL midrst_outputs: got req=%b we=%b busy=%b addr=%h dout=%h cnt=%0d chk=%h want 0",
                     bios_req, mem_we, busy, mem_addr, mem_dout, word_cnt, checksum);
        end
        repeat (3) @(negedge clk_sdr);
        pending = 0;
        exp_q.delete();
        obs_q.delete();
        reset_n = 1'b1;
        pulse_dl_start();
        next_word = 16'h3000;
        pending = 1;
        wait_obs(32, 1000);
        repeat (4) @(negedge clk_sdr);
        n_cmp++;
        if (obs_q.size() != 32 || exp_q.size() != 32) begin
            n_bad++;
            $display("FAIL midrst_count: got obs=%0d exp=%0d want 32", obs_q.size(), exp_q.size());
        end
        n_cmp++;
        if (obs_q.size() > 0 && obs_q[0].addr !== 18'h3F000) begin
            n_bad++;
            $display("FAIL midrst_first_addr: got %h want 3f000", obs_q[0].addr);
        end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            n_cmp++;
            if (o !== e) begin
                n_bad++;
                $display("FAIL midrst_write: got %h/%h want %h/%h", o.addr, o.data, e.addr, e.data);
            end
        end
    endtask

    task automatic test_wrap();
        wr_t o, e;
        logic [17:0] wa;
        pulse_dl_start();
        next_word = 16'h4000;
        pending = 257;
        wait_obs(8224, 40000);
        repeat (4) @(negedge clk_sdr);
        n_cmp++;
        if (obs_q.size() != 8224 || exp_q.size() != 8224) begin
            n_bad++;
            $display("FAIL wrap_count: got obs=%0d exp=%0d want 8224", obs_q.size(), exp_q.size());
        end
        for (int i = 0; obs_q.size() > 0 && exp_q.size() > 0; i++) begin
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            n_cmp++;
            if (o !== e) begin
                n_bad++;
                $display("FAIL wrap_write: #%0d got %h/%h want %h/%h", i, o.addr, o.data, e.addr, e.data);
            end
            if (i >= 8190 && i <= 8193) begin
                wa = 18'(BASE + 32'(i % 8192));
                n_cmp++;
                if (o.addr !== wa) begin
                    n_bad++;
                    $display("FAIL wrap_addr: #%0d got %h want %h", i, o.addr, wa);
                end
            end
        end
        n_cmp++;
        if (word_cnt !== 13'd32) begin
            n_bad++;
            $display("FAIL wrap_cnt: got %0d want 32", word_cnt);
        end
    endtask

    task automatic test_checksum();
        wr_t o, e;
        logic [15:0] want;
        pulse_dl_start();
        dq.push_back(16'hFFFF);
        dq.push_back(16'h0002);
        for (int i = 0; i < 30; i++) dq.push_back(16'h0000);
        pending = 1;
        wait_obs(32, 1000);
        repeat (4) @(negedge clk_sdr);
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            n_cmp++;
            if (o !== e) begin
                n_bad++;
                $display("FAIL chk_write: got %h/%h want %h/%h", o.addr, o.data, e.addr, e.data);
            end
        end
`ifdef BIOS_SINK_CHECKSUM_EN
        want = 16'h0001;
`else
        want = 16'h0000;
`endif
        n_cmp++;
        if (checksum !== want) begin
            n_bad++;
            $display("FAIL chk_value: got %h want %h", checksum, want);
        end
    endtask

    initial begin
        test_reset();
        test_single_burst();
        test_back_to_back();
        test_stall();
        test_reset_mid_pull();
        test_wrap();
        test_checksum();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
